mem_access_stage: RTL and testbench

- MEM pipeline stage, directly upstream of MEM_WB. Consumes EX_MEM outputs: address (ALUout), store data, funct3 and the memread/memwrite controls.
- Performs byte/halfword/word loads and stores over a ready-handshake data-memory port.
- Stalls the pipeline while an access is outstanding.
- Produces the load data, data address and invalid flag that MEM_WB registers.

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/mem_align.sv | 72 +++++++
 rtl/mem_access_stage.sv | 139 +++++++++++++
 tb/tb_mem_access_stage.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the data-memory access path: funct3 codes,
// MEM-stage FSM states and byte-enable patterns.
package riscv_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [3:0] BE_NONE    = 4'b0000;
   localparam logic [3:0] BE_BYTE0   = 4'b0001;
   localparam logic [3:0] BE_HALF_LO = 4'b0011;
   localparam logic [3:0] BE_HALF_HI = 4'b1100;
   localparam logic [3:0] BE_WORD    = 4'b1111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } mem_state_t;

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: byte enables and replicated store data,
// load extraction/extension, and legality/alignment classification.
module mem_align
   import riscv_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic        is_load_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] load_o,
   output logic        misaligned_o,
   output logic        illegal_o
);

   logic [7:0]  lanes [4];
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign lanes[gi] = rdata_i[8*gi +: 8];
      end
   endgenerate

   assign byte_sel = lanes[addr_lo_i];
   assign half_sel = addr_lo_i[1] ? {lanes[3], lanes[2]} : {lanes[1], lanes[0]};

   always_comb begin
      be_o         = BE_NONE;
      wdata_o      = 32'h0;
      load_o       = 32'h0;
      misaligned_o = 1'b0;
      illegal_o    = 1'b0;
      case (funct3_i)
         F3_B: begin
            be_o    = BE_BYTE0 << addr_lo_i;
            wdata_o = {4{wdata_i[7:0]}};
            load_o  = {{24{byte_sel[7]}}, byte_sel};
         end
         F3_H: begin
            be_o         = addr_lo_i[1] ? BE_HALF_HI : BE_HALF_LO;
            wdata_o      = {2{wdata_i[15:0]}};
            load_o       = {{16{half_sel[15]}}, half_sel};
            misaligned_o = addr_lo_i[0];
         end
         F3_W: begin
            be_o         = BE_WORD;
            wdata_o      = wdata_i;
            load_o       = rdata_i;
            misaligned_o = |addr_lo_i;
         end
         // Unsigned variants exist only for loads.
         F3_BU: begin
            be_o      = BE_BYTE0 << addr_lo_i;
            load_o    = {24'h0, byte_sel};
            illegal_o = ~is_load_i;
         end
         F3_HU: begin
            be_o         = addr_lo_i[1] ? BE_HALF_HI : BE_HALF_LO;
            load_o       = {16'h0, half_sel};
            misaligned_o = addr_lo_i[0];
            illegal_o    = ~is_load_i;
         end
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues one load/store over a ready-handshake port,
// stalls upstream while it is outstanding, and flags timeouts as bus errors.
module mem_access_stage
   import riscv_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        memread_in,
   input  logic        memwrite_in,
   input  logic [2:0]  funct3_in,
   input  logic [31:0] ALUout_in,
   input  logic [31:0] Wdata_in,
   input  logic        invalid_in,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        stall_out,
   output logic [31:0] Rdata_out,
   output logic [31:0] Data_addr_out,
   output logic        invalid_out
);

   mem_state_t        state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              mem_req_q;
   logic              mem_we_q;
   logic [31:0]       mem_addr_q;
   logic [31:0]       mem_wdata_q;
   logic [3:0]        mem_be_q;
   logic [31:0]       rdata_q;
   logic              bus_err_q;

   logic        access;
   logic        is_store;
   logic [3:0]  be_w;
   logic [31:0] wdata_w;
   logic [31:0] load_w;
   logic        misaligned_w;
   logic        illegal_w;
   logic        req_ok;

   // A load takes priority when both controls are set.
   assign access   = memread_in | memwrite_in;
   assign is_store = memwrite_in & ~memread_in;

   mem_align u_align (
      .funct3_i     (funct3_in),
      .is_load_i    (memread_in),
      .addr_lo_i    (ALUout_in[1:0]),
      .wdata_i      (Wdata_in),
      .rdata_i      (mem_rdata),
      .be_o         (be_w),
      .wdata_o      (wdata_w),
      .load_o       (load_w),
      .misaligned_o (misaligned_w),
      .illegal_o    (illegal_w)
   );

   assign req_ok = access & ~illegal_w & ~misaligned_w;

   // EX_MEM is frozen while stalled, so the live funct3/address still
   // describe the outstanding access when the read data returns.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'h0;
         mem_wdata_q <= 32'h0;
         mem_be_q    <= BE_NONE;
         rdata_q     <= 32'h0;
         bus_err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               rdata_q   <= 32'h0;
               bus_err_q <= 1'b0;
               if (req_ok) begin
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= is_store;
                  mem_addr_q  <= {ALUout_in[31:2], 2'b00};
                  mem_be_q    <= be_w;
                  mem_wdata_q <= is_store ? wdata_w : 32'h0;
                  cnt_q       <= '0;
                  state_q     <= REQ;
               end
            end
            REQ: begin
               if (mem_ready) begin
                  rdata_q     <= memread_in ? load_w : 32'h0;
                  mem_req_q   <= 1'b0;
                  mem_we_q    <= 1'b0;
                  mem_addr_q  <= 32'h0;
                  mem_wdata_q <= 32'h0;
                  mem_be_q    <= BE_NONE;
                  state_q     <= DONE;
               end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  rdata_q     <= 32'h0;
                  bus_err_q   <= 1'b1;
                  mem_req_q   <= 1'b0;
                  mem_we_q    <= 1'b0;
                  mem_addr_q  <= 32'h0;
                  mem_wdata_q <= 32'h0;
                  mem_be_q    <= BE_NONE;
                  state_q     <= DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DONE: begin
               rdata_q   <= 32'h0;
               bus_err_q <= 1'b0;
               state_q   <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mem_req       = mem_req_q;
   assign mem_we        = mem_we_q;
   assign mem_addr      = mem_addr_q;
   assign mem_wdata     = mem_wdata_q;
   assign mem_be        = mem_be_q;
   assign Rdata_out     = rdata_q;
   assign Data_addr_out = ALUout_in;

   assign stall_out   = rst_n & (((state_q == IDLE) & req_ok) | (state_q == REQ));
   assign invalid_out = invalid_in | (access & (illegal_w | misaligned_w)) | bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed and randomized transactions against a size/lane reference model.
module tb_mem_access_stage;

   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        memread_in, memwrite_in, invalid_in;
   logic [2:0]  funct3_in;
   logic [31:0] ALUout_in, Wdata_in;
   logic        mem_req, mem_we, mem_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;
   logic        stall_out, invalid_out;
   logic [31:0] Rdata_out, Data_addr_out;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_access_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .memread_in    (memread_in),
      .memwrite_in   (memwrite_in),
      .funct3_in     (funct3_in),
      .ALUout_in     (ALUout_in),
      .Wdata_in      (Wdata_in),
      .invalid_in    (invalid_in),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_be        (mem_be),
      .mem_ready     (mem_ready),
      .mem_rdata     (mem_rdata),
      .stall_out     (stall_out),
      .Rdata_out     (Rdata_out),
      .Data_addr_out (Data_addr_out),
      .invalid_out   (invalid_out)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Reference: access size in bytes, unsigned flag, lane arithmetic.
   function automatic void model(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [31:0] rd,
                                 output bit bad, output logic [3:0] be,
                                 output logic [31:0] wdo, output logic [31:0] ldv);
      int size = 0;
      bit uns  = 0;
      int k    = int'(a[1:0]);
      logic [31:0] mask, val;
      case (f3)
         3'd0: size = 1;
         3'd1: size = 2;
         3'd2: size = 4;
         3'd4: begin size = 1; uns = 1; end
         3'd5: begin size = 2; uns = 1; end
         default: size = 0;
      endcase
      bad = (size == 0) || (!ld && uns) || ((a % size) != 0);
      if (size == 0) size = 1;
      be   = 4'(((1 << size) - 1) << k);
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 1);
      if (size == 1)      wdo = (wd & 32'hFF) * 32'h0101_0101;
      else if (size == 2) wdo = (wd & 32'hFFFF) * 32'h0001_0001;
      else                wdo = wd;
      val = (rd >> (8 * k)) & mask;
      if (!uns && size < 4 && ((val >> (8 * size - 1)) & 1) == 1) val = val | ~mask;
      ldv = val;
   endfunction

   task automatic run_txn(input bit rd_en, input bit wr_en, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdw,
                          input int waits, input bit inv);
      bit bad, err;
      logic [3:0] ebe;
      logic [31:0] ewd, eld;
      int exp_req, req_n, stall_n;
      model(rd_en, f3, a, wd, rdw, bad, ebe, ewd, eld);
      @(negedge clk);
      memread_in = rd_en; memwrite_in = wr_en; funct3_in = f3; ALUout_in = a;
      Wdata_in = wd; invalid_in = inv; mem_rdata = rdw; mem_ready = 1'b0;
      #1;
      check("data_addr", Data_addr_out, a);
      if (bad) begin
         check("bad_stall", 32'(stall_out), 0);
         check("bad_invalid", 32'(invalid_out), 1);
         @(negedge clk);
         check("bad_req", 32'(mem_req), 0);
         check("bad_rdata", Rdata_out, 0);
         check("bad_stall2", 32'(stall_out), 0);
         memread_in = 1'b0; memwrite_in = 1'b0; invalid_in = 1'b0;
         $display("txn rd=%0b wr=%0b f3=%0d addr=%08h rejected", rd_en, wr_en, f3, a);
         return;
      end
      check("idle_stall", 32'(stall_out), 1);
      check("idle_invalid", 32'(invalid_out), 32'(inv));
      err     = (waits >= TIMEOUT);
      exp_req = err ? TIMEOUT : waits + 1;
      stall_n = 1;
      req_n   = 0;
      @(negedge clk);
      while (mem_req === 1'b1 && req_n < 40) begin
         check("req_addr", mem_addr, a & 32'hFFFF_FFFC);
         check("req_be", 32'(mem_be), 32'(ebe));
         check("req_we", 32'(mem_we), rd_en ? 0 : 1);
         check("req_wdata", mem_wdata, rd_en ? 32'h0 : ewd);
         if (stall_out === 1'b1) stall_n++;
         mem_ready = (req_n == waits);
         req_n++;
         @(negedge clk);
         mem_ready = 1'b0;
      end
      check("req_cycles", 32'(req_n), 32'(exp_req));
      check("stall_cycles", 32'(stall_n), 32'(exp_req + 1));
      check("done_stall", 32'(stall_out), 0);
      check("done_rdata", Rdata_out, (rd_en && !err) ? eld : 32'h0);
      check("done_invalid", 32'(invalid_out), 32'(inv | err));
      memread_in = 1'b0; memwrite_in = 1'b0; invalid_in = 1'b0;
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      check("gap_req", 32'(mem_req), 0);
      check("gap_rdata", Rdata_out, 0);
      check("gap_invalid", 32'(invalid_out), 0);
      $display("txn rd=%0b wr=%0b f3=%0d addr=%08h wd=%08h rd=%08h waits=%0d req=%0d rdata=%08h",
               rd_en, wr_en, f3, a, wd, rdw, waits, req_n, (rd_en && !err) ? eld : 32'h0);
   endtask

   initial begin
      rst_n = 1'b0; memread_in = 1'b0; memwrite_in = 1'b0; invalid_in = 1'b0;
      funct3_in = 3'd0; ALUout_in = 32'h0; Wdata_in = 32'h0;
      mem_ready = 1'b0; mem_rdata = 32'h0;
      repeat (2) @(negedge clk);
      check("rst_req", 32'(mem_req), 0);
      check("rst_be", 32'(mem_be), 0);
      check("rst_addr", mem_addr, 0);
      check("rst_rdata", Rdata_out, 0);
      check("rst_stall", 32'(stall_out), 0);
      rst_n = 1'b1;

      // Directed cases from the test plan.
      run_txn(1, 0, 3'b010, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, 0, 0);
      run_txn(1, 0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_FF7F, 1, 0);
      run_txn(1, 0, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF_FF7F, 0, 0);
      run_txn(1, 0, 3'b101, 32'h0000_0102, 32'h0, 32'h80FF_FF7F, 2, 0);
      run_txn(0, 1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h5555_5555, 3, 0);
      run_txn(0, 1, 3'b000, 32'h0000_0301, 32'h0000_00A5, 32'h0, 0, 0);
      run_txn(1, 0, 3'b010, 32'h0000_0101, 32'h0, 32'h0, 0, 0);
      run_txn(1, 0, 3'b011, 32'h0000_0100, 32'h0, 32'h0, 0, 0);
      run_txn(0, 1, 3'b100, 32'h0000_0100, 32'h0, 32'h0, 0, 0);
      run_txn(1, 1, 3'b001, 32'h0000_0406, 32'hFFFF_FFFF, 32'h7FFF_0000, 0, 1);
      run_txn(1, 0, 3'b010, 32'h0000_0500, 32'h0, 32'h1111_2222, 100, 0);
      run_txn(1, 0, 3'b010, 32'h0000_0504, 32'h0, 32'h3333_4444, 15, 0);

      // Reset on the second REQ cycle abandons the access.
      @(negedge clk);
      memread_in = 1'b1; funct3_in = 3'b010; ALUout_in = 32'h0000_0600;
      @(negedge clk);
      check("mid_req1", 32'(mem_req), 1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_stall_in_reset", 32'(stall_out), 0);
      @(negedge clk);
      check("mid_req", 32'(mem_req), 0);
      check("mid_we", 32'(mem_we), 0);
      check("mid_addr", mem_addr, 0);
      check("mid_be", 32'(mem_be), 0);
      check("mid_rdata", Rdata_out, 0);
      memread_in = 1'b0; rst_n = 1'b1;
      run_txn(1, 0, 3'b010, 32'h0000_0600, 32'h0, 32'hCAFE_F00D, 1, 0);

      for (int i = 0; i < 40; i++) begin
         bit rd, wr, inv;
         logic [2:0] f3;
         logic [31:0] a;
         int waits;
         rd = 1'($urandom_range(0, 1));
         wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom;
         if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
         waits = ($urandom_range(0, 9) == 0) ? 16 + $urandom_range(0, 3) : $urandom_range(0, 5);
         inv = ($urandom_range(0, 7) == 0);
         run_txn(rd, wr, f3, a, $urandom, $urandom, waits, inv);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
